// File: rtl/pad_gpio_pkg.sv
// Shared constants for the GPIO pad bank: register indices and the bank-size limit.
package pad_gpio_pkg;

  localparam int WIDTH_MAX = 32;

  localparam logic [2:0] GPIO_OUT     = 3'd0;
  localparam logic [2:0] GPIO_OE      = 3'd1;
  localparam logic [2:0] GPIO_IN      = 3'd2;
  localparam logic [2:0] GPIO_RISE_IE = 3'd3;
  localparam logic [2:0] GPIO_FALL_IE = 3'd4;
  localparam logic [2:0] GPIO_PENDING = 3'd5;
  localparam logic [2:0] GPIO_OD      = 3'd6;
  localparam logic [2:0] GPIO_RSVD    = 3'd7;

endpackage

// File: rtl/pad_gpio_sync_edge.sv
// One pad input: two-flop synchroniser, previous-value flop and edge detection.
module pad_gpio_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic pad_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= pad_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/pad_gpio_bank.sv
// Register front end for a bank of bidirectional pads: drive control, input
// synchronisation, edge-triggered pending bits and a level interrupt.
module pad_gpio_bank
  import pad_gpio_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bus_sel,
  input  logic             bus_write,
  input  logic [2:0]       bus_addr,
  input  logic [WIDTH-1:0] bus_wdata,
  output logic [WIDTH-1:0] bus_rdata,
  output logic [WIDTH-1:0] pad_din,
  output logic [WIDTH-1:0] pad_oen,
  input  logic [WIDTH-1:0] pad_dout,
  output logic             irq
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] rise_ie_q, rise_ie_d;
  logic [WIDTH-1:0] fall_ie_q, fall_ie_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] od_q, od_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             irq_q;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] sync_w, rise_w, fall_w;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      pad_gpio_sync_edge u_sync (
        .clk    (clk),
        .reset  (reset),
        .pad_i  (pad_dout[gi]),
        .sync_o (sync_w[gi]),
        .rise_o (rise_w[gi]),
        .fall_o (fall_w[gi])
      );
      // Open-drain only ever pulls low; a 1 releases the pad.
      assign pad_din[gi] = od_q[gi] ? 1'b0 : out_q[gi];
      assign pad_oen[gi] = od_q[gi] ? ~(oe_q[gi] & ~out_q[gi]) : ~oe_q[gi];
    end
  endgenerate

  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_ie_d = rise_ie_q;
    fall_ie_d = fall_ie_q;
    od_d      = od_q;
    clr_mask  = '0;
    if (bus_sel && bus_write) begin
      case (bus_addr)
        GPIO_OUT:     out_d     = bus_wdata;
        GPIO_OE:      oe_d      = bus_wdata;
        GPIO_RISE_IE: rise_ie_d = bus_wdata;
        GPIO_FALL_IE: fall_ie_d = bus_wdata;
        GPIO_PENDING: clr_mask  = bus_wdata;
        GPIO_OD:      od_d      = bus_wdata;
        default:      ;
      endcase
    end
    // New edges are ORed in after the clear so a coincident set survives.
    pending_d = (pending_q & ~clr_mask) | (rise_w & rise_ie_q) | (fall_w & fall_ie_q);

    rdata_d = rdata_q;
    if (bus_sel && !bus_write) begin
      case (bus_addr)
        GPIO_OUT:     rdata_d = out_q;
        GPIO_OE:      rdata_d = oe_q;
        GPIO_IN:      rdata_d = sync_w;
        GPIO_RISE_IE: rdata_d = rise_ie_q;
        GPIO_FALL_IE: rdata_d = fall_ie_q;
        GPIO_PENDING: rdata_d = pending_q;
        GPIO_OD:      rdata_d = od_q;
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      oe_q      <= '0;
      rise_ie_q <= '0;
      fall_ie_q <= '0;
      pending_q <= '0;
      od_q      <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_ie_q <= rise_ie_d;
      fall_ie_q <= fall_ie_d;
      pending_q <= pending_d;
      od_q      <= od_d;
      rdata_q   <= rdata_d;
      irq_q     <= |pending_q;
    end
  end

  assign bus_rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_pad_gpio_bank.sv
// Directed bench for pad_gpio_bank: drive, loopback input, edge interrupts, bus and reset.
module tb_pad_gpio_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bus_sel = 1'b0;
  logic       bus_write = 1'b0;
  logic [2:0] bus_addr = 3'd0;
  logic [7:0] bus_wdata = 8'h00;
  logic [7:0] bus_rdata;
  logic [7:0] pad_din;
  logic [7:0] pad_oen;
  logic [7:0] pad_dout;
  logic       irq;

  logic       loop_en = 1'b0;
  logic [7:0] pad_drv = 8'h00;
  int         n_cmp = 0;
  int         n_err = 0;

  // Loopback model: driven pads return DIN, released pads read as 0.
  assign pad_dout = loop_en ? (pad_din & ~pad_oen) : pad_drv;

  always #5 clk = ~clk;

  pad_gpio_bank #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_sel   (bus_sel),
    .bus_write (bus_write),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .pad_din   (pad_din),
    .pad_oen   (pad_oen),
    .pad_dout  (pad_dout),
    .irq       (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Both bus tasks are entered and left on a falling edge.
  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    bus_sel = 1'b1; bus_write = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_sel = 1'b0; bus_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, input string tag, input logic [7:0] exp);
    bus_sel = 1'b1; bus_write = 1'b0; bus_addr = a;
    @(negedge clk);
    bus_sel = 1'b0;
    chk(tag, {24'h0, bus_rdata}, {24'h0, exp});
  endtask

  initial begin
    #1;
    chk("rst_oen",   {24'h0, pad_oen},   32'hFF);
    chk("rst_din",   {24'h0, pad_din},   32'h00);
    chk("rst_irq",   {31'h0, irq},       32'h0);
    chk("rst_rdata", {24'h0, bus_rdata}, 32'h00);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Push-pull drive and loopback
    bus_wr(3'd0, 8'hA5);
    bus_wr(3'd1, 8'h0F);
    chk("pp_din", {24'h0, pad_din}, 32'hA5);
    chk("pp_oen", {24'h0, pad_oen}, 32'hF0);
    loop_en = 1'b1;
    repeat (3) @(negedge clk);
    bus_rd(3'd2, "pp_in", 8'h05);

    // Back-to-back reads of OUT, OE, reserved
    bus_sel = 1'b1; bus_write = 1'b0; bus_addr = 3'd0;
    @(negedge clk);
    chk("b2b_out", {24'h0, bus_rdata}, 32'hA5);
    bus_addr = 3'd1;
    @(negedge clk);
    chk("b2b_oe", {24'h0, bus_rdata}, 32'h0F);
    bus_addr = 3'd7;
    @(negedge clk);
    bus_sel = 1'b0;
    chk("b2b_rsvd", {24'h0, bus_rdata}, 32'h00);
    bus_wr(3'd2, 8'hFF);
    bus_rd(3'd2, "in_ro", 8'h05);
    bus_wr(3'd7, 8'hFF);
    bus_rd(3'd7, "rsvd_wr", 8'h00);

    // Open-drain on bit 0, push-pull elsewhere
    loop_en = 1'b0;
    bus_wr(3'd0, 8'h00);
    bus_wr(3'd1, 8'h01);
    bus_wr(3'd6, 8'h01);
    chk("od0_oen", {24'h0, pad_oen}, 32'hFE);
    chk("od0_din", {24'h0, pad_din}, 32'h00);
    bus_wr(3'd0, 8'h03);
    chk("od1_oen", {24'h0, pad_oen}, 32'hFF);
    chk("od1_din", {24'h0, pad_din}, 32'h02);
    bus_rd(3'd6, "od_rd", 8'h01);
    bus_wr(3'd6, 8'h00);
    bus_wr(3'd1, 8'h00);
    bus_wr(3'd0, 8'h00);
    repeat (4) @(negedge clk);

    // Rising edge on pad 2
    bus_wr(3'd3, 8'h04);
    pad_drv = 8'h04;
    @(negedge clk);                                // after E0
    @(negedge clk);                                // after E1
    bus_sel = 1'b1; bus_write = 1'b0; bus_addr = 3'd5;
    @(negedge clk);                                // after E2
    chk("rise_preset", {24'h0, bus_rdata}, 32'h00);
    chk("rise_irq_e2", {31'h0, irq}, 32'h0);
    @(negedge clk);                                // after E3
    bus_sel = 1'b0;
    chk("rise_pend", {24'h0, bus_rdata}, 32'h04);
    chk("rise_irq_e3", {31'h0, irq}, 32'h1);
    bus_wr(3'd5, 8'h04);
    chk("w1c_irq_1", {31'h0, irq}, 32'h1);
    @(negedge clk);
    chk("w1c_irq_2", {31'h0, irq}, 32'h0);
    bus_rd(3'd5, "w1c_pend", 8'h00);

    // Bit 3 high with no rise enable: no pending recorded
    bus_wr(3'd4, 8'h08);
    pad_drv = 8'h0C;
    repeat (4) @(negedge clk);
    bus_rd(3'd5, "rise_noie", 8'h00);

    // Falling edge on bit 3 with coincident w1c; rising edge on bit 1 with IE=0
    pad_drv = 8'h06;
    @(negedge clk);                                // after E0
    @(negedge clk);                                // after E1
    bus_wr(3'd5, 8'h08);                           // write lands on E2
    bus_rd(3'd5, "setwins", 8'h08);
    @(negedge clk);
    chk("setwins_irq", {31'h0, irq}, 32'h1);

    // Asynchronous reset mid-traffic
    bus_wr(3'd0, 8'h5A);
    bus_wr(3'd1, 8'hFF);
    bus_rd(3'd1, "pre_rst_oe", 8'hFF);
    pad_drv = 8'h00;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_oen",   {24'h0, pad_oen},   32'hFF);
    chk("arst_din",   {24'h0, pad_din},   32'h00);
    chk("arst_irq",   {31'h0, irq},       32'h0);
    chk("arst_rdata", {24'h0, bus_rdata}, 32'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus_rd(3'(i), $sformatf("arst_reg%0d", i), 8'h00);
    end
    chk("arst_irq_post", {31'h0, irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
